// File: rtl/base64_pkg.sv
// Shared base64 alphabet constants and the character-membership helper used by
// the stream decoder and its character-to-sextet lookup.
package base64_pkg;

    localparam int B64_CHAR_W   = 8;
    localparam int B64_SEXTET_W = 6;

    localparam logic [B64_CHAR_W-1:0] B64_UPPER_FIRST = 8'h41;  // 'A'
    localparam logic [B64_CHAR_W-1:0] B64_UPPER_LAST  = 8'h5A;  // 'Z'
    localparam logic [B64_CHAR_W-1:0] B64_LOWER_FIRST = 8'h61;  // 'a'
    localparam logic [B64_CHAR_W-1:0] B64_LOWER_LAST  = 8'h7A;  // 'z'
    localparam logic [B64_CHAR_W-1:0] B64_DIGIT_FIRST = 8'h30;  // '0'
    localparam logic [B64_CHAR_W-1:0] B64_DIGIT_LAST  = 8'h39;  // '9'
    localparam logic [B64_CHAR_W-1:0] B64_PLUS        = 8'h2B;  // '+'
    localparam logic [B64_CHAR_W-1:0] B64_SLASH       = 8'h2F;  // '/'

    function automatic logic b64_char_valid(input logic [B64_CHAR_W-1:0] c);
        return ((c >= B64_UPPER_FIRST) && (c <= B64_UPPER_LAST)) ||
               ((c >= B64_LOWER_FIRST) && (c <= B64_LOWER_LAST)) ||
               ((c >= B64_DIGIT_FIRST) && (c <= B64_DIGIT_LAST)) ||
               (c == B64_PLUS) || (c == B64_SLASH);
    endfunction

endpackage

// File: rtl/base64decoder.sv
// Combinational base64 character decoder: one ASCII code in, one sextet out,
// plus a flag saying whether the code belongs to the alphabet at all.
module base64decoder
    import base64_pkg::*;
(
    input  logic [B64_CHAR_W-1:0]   char_i,
    output logic [B64_SEXTET_W-1:0] sextet_o,
    output logic                    valid_o
);

    // Arithmetic is done modulo 64 on the low six bits only; range membership
    // still looks at the full byte through b64_char_valid.
    always_comb begin
        sextet_o = '0;
        valid_o  = b64_char_valid(char_i);
        if ((char_i >= B64_UPPER_FIRST) && (char_i <= B64_UPPER_LAST)) begin
            sextet_o = char_i[5:0] - B64_UPPER_FIRST[5:0];
        end else if ((char_i >= B64_LOWER_FIRST) && (char_i <= B64_LOWER_LAST)) begin
            sextet_o = char_i[5:0] - B64_LOWER_FIRST[5:0] + 6'd26;
        end else if ((char_i >= B64_DIGIT_FIRST) && (char_i <= B64_DIGIT_LAST)) begin
            sextet_o = char_i[5:0] - B64_DIGIT_FIRST[5:0] + 6'd52;
        end else if (char_i == B64_PLUS) begin
            sextet_o = 6'd62;
        end else if (char_i == B64_SLASH) begin
            sextet_o = 6'd63;
        end
    end

endmodule

// File: rtl/base64decoder_x8_stream.sv
// Serial base64 stream decoder: packs N_CHARS accepted characters into one word
// (char k lands in bits [6k+5:6k]) and holds it on a valid/ready output.
module base64decoder_x8_stream
    import base64_pkg::*;
#(
    parameter int N_CHARS   = 8,
    parameter int ERR_CNT_W = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [B64_CHAR_W-1:0]        char_i,
    input  logic                         char_valid_i,
    output logic                         char_ready_o,
    input  logic                         flush_i,
    output logic [B64_SEXTET_W*N_CHARS-1:0] word_o,
    output logic                         word_valid_o,
    input  logic                         word_ready_i,
    output logic                         err_o,
    output logic [ERR_CNT_W-1:0]         err_cnt_o
);

    localparam int              WORD_W = B64_SEXTET_W * N_CHARS;
    localparam int              CNT_W  = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_CHARS - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0]       acc_q, acc_d;
    logic [WORD_W-1:0]       word_q, word_d;
    logic                    word_valid_q, word_valid_d;
    logic                    err_q, err_d;
    logic [ERR_CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [B64_SEXTET_W-1:0] sextet;
    logic                    sextet_ok;
    logic                    accept;

    base64decoder u_decoder (
        .char_i   (char_i),
        .sextet_o (sextet),
        .valid_o  (sextet_ok)
    );

    // Only the group-completing char must wait for the held word to drain.
    assign char_ready_o = !flush_i && (!word_valid_q || word_ready_i || (cnt_q != LAST));
    assign accept       = char_valid_i && char_ready_o;

    always_comb begin
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        word_d       = word_q;
        word_valid_d = word_valid_q;
        err_d        = 1'b0;
        err_cnt_d    = err_cnt_q;

        if (word_valid_q && word_ready_i) begin
            word_valid_d = 1'b0;
        end

        if (flush_i) begin
            cnt_d = '0;
        end else if (accept) begin
            if (!sextet_ok) begin
                err_d = 1'b1;
                cnt_d = '0;
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
            end else begin
                for (int k = 0; k < N_CHARS; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        acc_d[B64_SEXTET_W*k +: B64_SEXTET_W] = sextet;
                    end
                end
                if (cnt_q == LAST) begin
                    word_d       = acc_d;
                    word_valid_d = 1'b1;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = word_valid_q;
    assign err_o        = err_q;
    assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_base64decoder_x8_stream.sv
// Directed self-checking bench for base64decoder_x8_stream: known strings,
// random round trips through a reference encoder, backpressure, errors, reset, flush.
module tb_base64decoder_x8_stream;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [7:0]  char_i;
    logic        char_valid_i;
    logic        char_ready_o;
    logic        flush_i;
    logic [47:0] word_o;
    logic        word_valid_o;
    logic        word_ready_i;
    logic        err_o;
    logic [15:0] err_cnt_o;

    int compareCount = 0;
    int failCount    = 0;

    base64decoder_x8_stream #(.N_CHARS(8), .ERR_CNT_W(16)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .char_i       (char_i),
        .char_valid_i (char_valid_i),
        .char_ready_o (char_ready_o),
        .flush_i      (flush_i),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .err_o        (err_o),
        .err_cnt_o    (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Presents one char and returns #1 after the posedge that accepted it.
    task automatic applyStimulus(input logic [7:0] c);
        logic ok;
        int   budget;
        ok = 1'b0;
        budget = 0;
        char_i = c;
        char_valid_i = 1'b1;
        while (!ok && budget < 50) begin
            @(negedge clk_i);
            ok = char_ready_o;
            @(posedge clk_i);
            #1;
            budget++;
        end
        char_valid_i = 1'b0;
        if (!ok) begin
            compareCount++;
            failCount++;
            $error("[TB] FAIL handshake_timeout: char %0h observed not accepted expected accepted", c);
        end
    endtask

    task automatic sendString(input string s);
        for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
    endtask

    task automatic sendAndCheck(input string tag, input string s, input logic [47:0] expected);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(s[i]);
            if (i == 6) checkOutput({tag, "_early_valid"}, 64'(word_valid_o), 64'd0);
        end
        checkOutput({tag, "_valid"}, 64'(word_valid_o), 64'd1);
        checkOutput({tag, "_word"}, 64'(word_o), 64'(expected));
    endtask

    function automatic logic [7:0] encodeSextet(input logic [5:0] v);
        if (v < 6'd26)      return 8'h41 + {2'b00, v};
        else if (v < 6'd52) return 8'h61 + {2'b00, v} - 8'd26;
        else if (v < 6'd62) return 8'h30 + {2'b00, v} - 8'd52;
        else if (v == 6'd62) return 8'h2B;
        else                return 8'h2F;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] r;
        logic [47:0] x;

        rst_n_i = 1'b0;
        char_i = 8'h00;
        char_valid_i = 1'b0;
        flush_i = 1'b0;
        word_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checkOutput("rst_word", 64'(word_o), 64'd0);
        checkOutput("rst_valid", 64'(word_valid_o), 64'd0);
        checkOutput("rst_err", 64'(err_o), 64'd0);
        checkOutput("rst_errcnt", 64'(err_cnt_o), 64'd0);
        checkOutput("rst_ready", 64'(char_ready_o), 64'd1);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Test 1: all-zero word, single-cycle valid pulse.
        sendAndCheck("t1_zero", "AAAAAAAA", 48'h0);
        @(posedge clk_i);
        #1;
        checkOutput("t1_pulse_end", 64'(word_valid_o), 64'd0);

        // Test 2: sextet placement at both ends of the word.
        sendAndCheck("t2_low", "BAAAAAAA", 48'h000000000001);
        sendAndCheck("t2_high", "AAAAAAA/", 48'hFC0000000000);
        @(posedge clk_i);
        #1;

        // Test 3: random round trips, streamed back-to-back.
        for (int w = 0; w < 1000; w++) begin
            r = {$urandom(), $urandom()};
            x = r[47:0];
            for (int k = 0; k < 8; k++) applyStimulus(encodeSextet(x[6*k +: 6]));
            checkOutput("t3_valid", 64'(word_valid_o), 64'd1);
            checkOutput("t3_word", 64'(word_o), 64'(x));
        end
        @(posedge clk_i);
        #1;
        checkOutput("t3_drain", 64'(word_valid_o), 64'd0);

        // Test 4: backpressure; only the completing char stalls.
        word_ready_i = 1'b0;
        sendAndCheck("t4_w1", "BAAAAAAA", 48'h000000000001);
        sendString("/AAAAAA");
        checkOutput("t4_hold_valid", 64'(word_valid_o), 64'd1);
        char_i = "B";
        char_valid_i = 1'b1;
        repeat (12) begin
            @(negedge clk_i);
            checkOutput("t4_stall_ready", 64'(char_ready_o), 64'd0);
            checkOutput("t4_stable_word", 64'(word_o), 64'h000000000001);
            checkOutput("t4_stable_valid", 64'(word_valid_o), 64'd1);
        end
        @(posedge clk_i);
        #1;
        word_ready_i = 1'b1;
        @(negedge clk_i);
        checkOutput("t4_release_ready", 64'(char_ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        char_valid_i = 1'b0;
        checkOutput("t4_w2_valid", 64'(word_valid_o), 64'd1);
        checkOutput("t4_w2_word", 64'(word_o), 64'h04000000003F);
        @(posedge clk_i);
        #1;
        checkOutput("t4_w2_consumed", 64'(word_valid_o), 64'd0);

        // Test 5: '=' is rejected and the partial group is dropped.
        sendString("ABC=");
        checkOutput("t5_err_pulse", 64'(err_o), 64'd1);
        checkOutput("t5_err_cnt", 64'(err_cnt_o), 64'd1);
        checkOutput("t5_no_word", 64'(word_valid_o), 64'd0);
        @(posedge clk_i);
        #1;
        checkOutput("t5_err_end", 64'(err_o), 64'd0);
        sendAndCheck("t5_slash", "////////", 48'hFFFFFFFFFFFF);
        @(posedge clk_i);
        #1;

        // Test 6a: reset in the middle of a group.
        sendString("ABCDE");
        #2;
        rst_n_i = 1'b0;
        #1;
        checkOutput("t6a_word", 64'(word_o), 64'd0);
        checkOutput("t6a_valid", 64'(word_valid_o), 64'd0);
        checkOutput("t6a_errcnt", 64'(err_cnt_o), 64'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        sendAndCheck("t6a_fresh", "BAAAAAAA", 48'h000000000001);
        @(posedge clk_i);
        #1;

        // Test 6b: reset while a word is being held.
        word_ready_i = 1'b0;
        sendAndCheck("t6b_held", "////////", 48'hFFFFFFFFFFFF);
        #2;
        rst_n_i = 1'b0;
        #1;
        checkOutput("t6b_word", 64'(word_o), 64'd0);
        checkOutput("t6b_valid", 64'(word_valid_o), 64'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        word_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        sendAndCheck("t6b_fresh", "BAAAAAAA", 48'h000000000001);
        @(posedge clk_i);
        #1;

        // Test 6c: flush after three chars.
        sendString("ABC");
        flush_i = 1'b1;
        @(negedge clk_i);
        checkOutput("t6c_flush_ready", 64'(char_ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        sendAndCheck("t6c_fresh", "BAAAAAAA", 48'h000000000001);
        checkOutput("t6c_no_err", 64'(err_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
